aes_key_schedule: RTL
=====================

Name: aes_key_schedule

Overview:
Iterative AES-128 key expansion engine. It sits directly upstream of the AES decryption control unit and datapath. It expands a 128-bit cipher key into the 44-word schedule at one word per clock, and stores the schedule in internal registers. It then serves any of the 11 round keys by index, with a registered read, so the decryption rounds can consume keys in reverse order (10 down to 0).

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; the schedule holds 4*(NUM_ROUNDS+1)=44 words. Only 10 is supported.

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
KEY_START  input  1  single-cycle request to begin expansion of CIPHER_KEY
CIPHER_KEY  input  128  cipher key; bits [127:96] are word w0; sampled only in the start cycle
RK_SEL  input  4  round-key index, 0..10
ROUND_KEY  output  128  registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]} for r = RK_SEL of the previous cycle
KEY_BUSY  output  1  high while expansion is in progress
KEY_READY  output  1  high while the full schedule is valid

Behaviour:
- Reset (async): state=IDLE; word index=0; all 44 schedule words=0; ROUND_KEY=0; KEY_BUSY=0; KEY_READY=0.
- States:
  - IDLE: on KEY_START, go to EXPAND. At that edge, load w0..w3 from CIPHER_KEY and set the index to 4.
  - EXPAND: each edge writes w[i] and increments i. At the edge that writes w43, go to READY.
  - READY: on KEY_START, restart exactly as from IDLE (load w0..w3, index=4, go to EXPAND).
- Expansion arithmetic for word i:
  - If i mod 4 == 0: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ {Rcon[i/4],24'h0}.
  - Otherwise: w[i] = w[i-4] ^ w[i-1].
  - RotWord rotates bytes left by one: {b1,b2,b3,b0}.
  - SubWord applies the forward S-box to each of the 4 bytes; four combinational S-box instances.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Timing:
  - KEY_START sampled at edge k: KEY_BUSY is high from after edge k.
  - EXPAND occupies exactly 40 cycles (edges k+1..k+40 write w4..w43).
  - KEY_BUSY falls and KEY_READY rises after edge k+40.
  - KEY_BUSY and KEY_READY are never high together.
- KEY_START while in EXPAND is ignored. The current expansion completes, and CIPHER_KEY is not re-sampled.
- During EXPAND and after a restart from READY, KEY_READY=0. Round keys read during this time are undefined to the consumer, but must reflect the current register contents and must not produce X.
- Read path: ROUND_KEY registers on every edge from RK_SEL, regardless of state. Latency is 1 cycle. RK_SEL 11..15 yields 128'h0.
- Reset asserted mid-expansion: immediate return to IDLE with the schedule cleared. No partial results are retained.
- The index counter is 6 bits and is never allowed to pass 43. There is no wrap-around; leaving EXPAND resets it to 0.

Decomposition:
- Shared package aes_pkg holds:
  - the state enum (IDLE, EXPAND, READY)
  - the Rcon constant array
  - the word type (logic [31:0])
  - the round-key type (logic [127:0])
  - NUM_KEY_WORDS=44
- One sub-module: aes_sbox_lookup, an 8-bit in / 8-bit out combinational forward S-box. It is instantiated 4 times for SubWord and can be reused elsewhere in the cipher.

Test Plan:
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c, pulse KEY_START -> KEY_READY rises exactly 40 cycles after the start edge. Then:
  - RK_SEL=1 gives ROUND_KEY=a0fafe1788542cb123a339392a6c7605 one cycle later.
  - RK_SEL=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - RK_SEL=0 returns the cipher key.
- Reverse sweep RK_SEL=10..0, one per cycle -> each ROUND_KEY matches the FIPS-197 schedule with 1-cycle latency, back-to-back with no bubbles.
- Assert RESET at cycle 20 of EXPAND -> all outputs 0 immediately (async). Then a new KEY_START with key 000102030405060708090a0b0c0d0e0f -> round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- KEY_START pulsed again at EXPAND cycle 10 with a different CIPHER_KEY -> ignored; the original key's schedule completes at cycle 40 unchanged.
- KEY_START in READY with a new key -> KEY_READY drops next cycle, KEY_BUSY high for 40 cycles, new schedule correct.
- RK_SEL=13 in READY -> ROUND_KEY=0 next cycle; KEY_READY stays 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and constants: key-schedule FSM states, Rcon table, word/round-key types.
package aes_pkg;

  localparam int unsigned NUM_KEY_WORDS = 44;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned RK_W          = 128;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RK_W-1:0]   round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  // Indexed by i/4; entry 0 and 11..15 are never used for a valid word index.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/aes_sbox_lookup.sv
// Combinational AES forward S-box, 8-bit in / 8-bit out.
module aes_sbox_lookup (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion (one word per clock) with a registered round-key read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         KEY_START,
  input  logic [127:0] CIPHER_KEY,
  input  logic [3:0]   RK_SEL,
  output logic [127:0] ROUND_KEY,
  output logic         KEY_BUSY,
  output logic         KEY_READY
);

  localparam int unsigned IDX_W    = 6;
  localparam int unsigned LAST_IDX = 4 * (NUM_ROUNDS + 1) - 1;

  ks_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  round_key_t       round_key_q, round_key_d;
  word_t            w_q [NUM_KEY_WORDS];

  logic             load_c, wr_c;
  logic [IDX_W-1:0] widx_c, rbase_c;
  word_t            prev1_c, prev4_c, rot_c, sub_c, new_word_c;

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_c  = 1'b0;
    wr_c    = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (KEY_START) begin
          state_d = EXPAND;
          idx_d   = IDX_W'(4);
          load_c  = 1'b1;
        end
      end
      EXPAND: begin
        wr_c = 1'b1;
        if (idx_q == IDX_W'(LAST_IDX)) begin
          state_d = READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d  = (state_d == EXPAND);
    ready_d = (state_d == READY);
  end

  // Keep the neighbour reads in range when the index is parked at 0 outside EXPAND.
  assign widx_c  = (idx_q < IDX_W'(4)) ? IDX_W'(4) : idx_q;
  assign prev1_c = w_q[widx_c - IDX_W'(1)];
  assign prev4_c = w_q[widx_c - IDX_W'(4)];
  assign rot_c   = {prev1_c[23:0], prev1_c[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox_lookup u_sbox (
      .data_i (rot_c[8*g +: 8]),
      .data_o (sub_c[8*g +: 8])
    );
  end

  always_comb begin
    if (widx_c[1:0] == 2'b00) begin
      new_word_c = prev4_c ^ sub_c ^ {RCON[widx_c[5:2]], 24'h0};
    end else begin
      new_word_c = prev4_c ^ prev1_c;
    end
  end

  // Read path: out-of-range selects return zero.
  always_comb begin
    rbase_c     = '0;
    round_key_d = '0;
    if (RK_SEL <= 4'(NUM_ROUNDS)) begin
      rbase_c     = {RK_SEL, 2'b00};
      round_key_d = {w_q[rbase_c], w_q[rbase_c + IDX_W'(1)],
                     w_q[rbase_c + IDX_W'(2)], w_q[rbase_c + IDX_W'(3)]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      round_key_q <= '0;
      for (int i = 0; i < NUM_KEY_WORDS; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      round_key_q <= round_key_d;
      if (load_c) begin
        w_q[0] <= CIPHER_KEY[127:96];
        w_q[1] <= CIPHER_KEY[95:64];
        w_q[2] <= CIPHER_KEY[63:32];
        w_q[3] <= CIPHER_KEY[31:0];
      end else if (wr_c) begin
        w_q[idx_q] <= new_word_c;
      end
    end
  end

  assign ROUND_KEY = round_key_q;
  assign KEY_BUSY  = busy_q;
  assign KEY_READY = ready_q;

endmodule
